// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// One operation in flight: IDLE grants, EXEC lets the ALU settle, RESP holds the result.
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]      req_op,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [2:0]                alu_op,
    input  logic [DATA_W-1:0]         alu_out,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [2:0]          r_alu_op;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_busy;

    logic                w_found;
    logic [ID_W-1:0]     w_win;
    logic [ID_W-1:0]     w_next_ptr;
    logic [DATA_W-1:0]   w_sel_a;
    logic [DATA_W-1:0]   w_sel_b;
    logic [2:0]          w_sel_op;
    logic [NUM_REQ-1:0]  w_ready;
    int                  w_dist;
    int                  w_best;

    // Winner is the valid requester with the smallest distance from rr_ptr.
    always_comb begin
        w_found  = (req_valid != '0);
        w_win    = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = '0;
        w_dist   = 0;
        w_best   = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = i - int'(r_rr_ptr);
            if (w_dist < 0)
                w_dist = w_dist + NUM_REQ;
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_win    = ID_W'(i);
                w_sel_a  = req_a[i*DATA_W +: DATA_W];
                w_sel_b  = req_b[i*DATA_W +: DATA_W];
                w_sel_op = req_op[i*3 +: 3];
            end
        end
        w_next_ptr = (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
    end

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NUM_REQ; i++)
            w_ready[i] = (r_state == IDLE) && !rst && w_found && (w_win == ID_W'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_found) begin
                    r_alu_a  <= w_sel_a;
                    r_alu_b  <= w_sel_b;
                    r_alu_op <= w_sel_op;
                    r_id     <= w_win;
                    r_rr_ptr <= w_next_ptr;
                    r_state  <= EXEC;
                    r_busy   <= 1'b1;
                end
                EXEC: begin
                    r_rsp_data  <= alu_out;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = w_ready;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table plus hand-written sequences,
// with a response scoreboard fed as requests are driven.
module tb_alu_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*3-1:0] req_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [2:0]     alu_op;
    logic [W-1:0]   alu_out;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic [W-1:0]   rsp_data;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct { logic [IW-1:0] id; logic [W-1:0] data; } exp_t;
    typedef struct { int id; logic [W-1:0] a; logic [W-1:0] b; logic [2:0] op; logic [W-1:0] exp; } vec_t;

    exp_t sb[$];
    exp_t m_e;
    vec_t vt[10];

    alu_arbiter #(.NUM_REQ(N), .DATA_W(W), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU; also drives the DUT's alu_out.
    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[2:0];
            3'd6:    return a >> b[2:0];
            default: return ~a;
        endcase
    endfunction

    assign alu_out = alu_ref(alu_a, alu_b, alu_op);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard pops on each response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_id), 32'hFFFF_FFFF);
                end else begin
                    m_e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(m_e.id));
                    chk("rsp_data", 32'(rsp_data), 32'(m_e.data));
                end
            end
            chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        end
    end

    task automatic drive(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_op[id*3 +: 3] = op;
    endtask

    task automatic wait_grant(input logic [N-1:0] mask, input string name);
        int t = 0;
        @(negedge clk);
        while (req_ready == '0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk(name, 32'(req_ready), 32'(mask));
    endtask

    task automatic do_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op, input logic [W-1:0] exp);
        drive(id, a, b, op);
        req_valid = '0;
        req_valid[id] = 1'b1;
        sb.push_back('{IW'(id), exp});
        wait_grant(N'(1 << id), "grant");
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb, exp2;
        int last;

        vt[0] = '{0, 8'h12, 8'h34, 3'd0, 8'h46};
        vt[1] = '{1, 8'hF0, 8'h0F, 3'd1, 8'hE1};
        vt[2] = '{2, 8'hAA, 8'h0F, 3'd2, 8'h0A};
        vt[3] = '{3, 8'hA0, 8'h05, 3'd3, 8'hA5};
        vt[4] = '{0, 8'hFF, 8'h0F, 3'd4, 8'hF0};
        vt[5] = '{1, 8'hFF, 8'h01, 3'd0, 8'h00};
        vt[6] = '{2, 8'h00, 8'h01, 3'd1, 8'hFF};
        vt[7] = '{3, 8'h81, 8'h01, 3'd5, 8'h02};
        vt[8] = '{0, 8'h81, 8'h03, 3'd6, 8'h10};
        vt[9] = '{1, 8'h5A, 8'h00, 3'd7, 8'hA5};

        rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
        req_a = '0; req_b = '0; req_op = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0;

        // Single request: latency and busy window.
        @(posedge clk); #1;
        drive(0, 8'h12, 8'h34, 3'd0);
        req_valid = 4'b0001;
        sb.push_back('{2'd0, 8'h46});
        wait_grant(4'b0001, "t1_grant");
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("t1_alu_a", 32'(alu_a), 32'h12);
        chk("t1_alu_b", 32'(alu_b), 32'h34);
        chk("t1_alu_op", 32'(alu_op), 32'd0);
        chk("t1_busy_exec", 32'(busy), 32'd1);
        chk("t1_rsp_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_busy_resp", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t1_busy_done", 32'(busy), 32'd0);
        chk("t1_rsp_done", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            do_req(vt[i].id, vt[i].a, vt[i].b, vt[i].op, vt[i].exp);
        drain();

        // Fairness: all four valid from rr_ptr=0.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++)
            drive(i, 8'(17 * (i + 1)), 8'(3 + i), 3'(i));
        for (int g = 0; g < 8; g++)
            sb.push_back('{IW'(g % N), alu_ref(8'(17 * ((g % N) + 1)), 8'(3 + (g % N)), 3'(g % N))});
        req_valid = '1;
        last = 0;
        for (int g = 0; g < 8; g++) begin
            wait_grant(N'(1 << (g % N)), "rr_grant");
            if (g > 0) chk("rr_spacing", 32'(cyc - last), 32'd3);
            last = cyc;
            @(posedge clk); #1;
            if (g == 7) req_valid = '0;
        end
        drain();

        // Backpressure on requester 2; then 3 must win next.
        rsp_ready = 1'b0;
        exp2 = alu_ref(8'h5C, 8'h21, 3'd1);
        do_req(2, 8'h5C, 8'h21, 3'd1, exp2);
        drive(0, 8'h01, 8'h01, 3'd0);
        drive(1, 8'h02, 8'h02, 3'd0);
        drive(3, 8'h3C, 8'h0F, 3'd4);
        req_valid = 4'b1011;
        sb.push_back('{2'd3, 8'h33});
        begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!rsp_valid && t < 10);
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_id", 32'(rsp_id), 32'd2);
            chk("bp_rsp_data", 32'(rsp_data), 32'(exp2));
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_grant(4'b1000, "bp_next_grant");
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        // Pointer wrap: 3 then 0, then rr_ptr=1 favours requester 1 over 0.
        do_req(3, 8'h10, 8'h20, 3'd0, 8'h30);
        do_req(0, 8'h0F, 8'hF0, 3'd3, 8'hFF);
        drive(0, 8'h11, 8'h11, 3'd0);
        drive(1, 8'h77, 8'h07, 3'd2);
        req_valid = 4'b0011;
        sb.push_back('{2'd1, 8'h07});
        wait_grant(4'b0010, "wrap_ptr1_grant");
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        // Reset while in EXEC: no response may appear.
        drive(2, 8'h44, 8'h44, 3'd0);
        req_valid = 4'b0100;
        wait_grant(4'b0100, "rst_grant");
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy_exec", 32'(busy), 32'd1);
        @(negedge clk);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_alu", 32'({alu_a, alu_b, 5'd0, alu_op}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        for (int i = 0; i < N; i++)
            drive(i, 8'(i + 1), 8'h10, 3'd0);
        req_valid = '1;
        sb.push_back('{2'd0, 8'h11});
        wait_grant(4'b0001, "post_rst_grant");
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        // Sweep all op codes on rotating requesters.
        for (int r = 0; r < 3; r++) begin
            for (int op = 0; op < 8; op++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                do_req((r * 8 + op) % N, ra, rb, 3'(op), alu_ref(ra, rb, 3'(op)));
            end
        end
        drain();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares a single combinational 8-bit ALU (inputs a, b, op_code[2:0]; output alu_out) among NUM_REQ independent requesters.
- Uses round-robin arbitration, a valid/ready request handshake per requester, and a registered, held response tagged with the requester index.
- Sits between the ALU instance and the pipeline and control units that need ALU operations outside the main datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, operand and result width; must match the ALU width.
- ID_W, 2, width of the requester index; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*DATA_W  operand a; requester i uses slice [i*DATA_W +: DATA_W].
- req_b  input  NUM_REQ*DATA_W  operand b; same slicing as req_a.
- req_op  input  NUM_REQ*3  op code; requester i uses slice [i*3 +: 3].
- alu_a  output  DATA_W  to ALU a.
- alu_b  output  DATA_W  to ALU b.
- alu_op  output  3  to ALU op_code.
- alu_out  input  DATA_W  from ALU result.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept from consumer.
- rsp_id  output  ID_W  index of the requester that owns rsp_data.
- rsp_data  output  DATA_W  registered ALU result.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: all state is cleared on the rising clk edge while rst=1.
- Reset values:
  - state = IDLE.
  - rr_ptr = 0.
  - alu_a, alu_b, alu_op = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0.
  - busy = 0.
  - req_ready = 0, held at 0 while rst=1.
- State machine states: IDLE, EXEC, RESP.
- IDLE:
  - The winner w is the first index i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_REQ.
  - req_ready is combinational: req_ready[w]=1 only in IDLE and only when some req_valid is high. Otherwise req_ready=0.
  - When a transfer occurs (req_valid[w] & req_ready[w]):
    - latch req_a, req_b, req_op slices of w into alu_a, alu_b, alu_op;
    - latch w into id_reg;
    - set rr_ptr = (w+1) mod NUM_REQ;
    - go to EXEC.
  - With no valid request: stay in IDLE; rr_ptr and alu_* are unchanged.
- EXEC (exactly 1 cycle):
  - The ALU settles on the registered operands.
  - At the clock edge: rsp_data <= alu_out, rsp_id <= id_reg, rsp_valid <= 1, go to RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_ready=1 is sampled.
  - On that edge: rsp_valid <= 0, go to IDLE.
  - No new grant is issued in the handshake cycle.
- Timing:
  - Latency from accept edge T to rsp_valid high is 2 cycles (rsp_valid is high from T+2).
  - Minimum issue interval is 3 cycles.
  - rsp_ready held high gives 1 cycle in RESP.
- Fairness: with all requesters valid, grants rotate 0,1,2,3,0,... No requester waits more than NUM_REQ-1 grants.
- Requester obligation: hold req_valid and operands stable until req_ready is seen. The block never drops a grant while in IDLE.
- Arithmetic: op codes pass through uninterpreted; rsp_data is bit-exact alu_out. There is no width extension or carry port.
- rsp_ready asserted while not in RESP is ignored.
- req_valid deasserted while the request is in flight has no effect; the operation completes.
- Reset mid-operation (EXEC or RESP): the operation is aborted, no response is delivered, and all state returns to reset values on that edge.
- busy = (state != IDLE).

Test Plan:
- Reset then single request: req_valid=0001, a0=8'h12, b0=8'h34, op0=3'b000, accepted at edge T.
  - alu_a=8'h12, alu_b=8'h34, alu_op=0 at T+1.
  - rsp_valid=1 at T+2 with rsp_id=0 and rsp_data equal to the reference ALU model output for (12,34,000).
  - busy=1 for 2 cycles.
- All four valid continuously, rsp_ready=1, distinct operands: grant order is 0,1,2,3,0,1,2,3. Each response is tagged with the matching rsp_id, and responses are 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid. rsp_valid, rsp_id and rsp_data stay stable, req_ready stays 0000 and no other request is accepted. rsp_ready=1 frees the block, and the next grant goes to (prev+1).
- Pointer wrap: only requester 3 valid, then only requester 0 valid with rr_ptr=0 after the first grant. Requester 0 is granted next; rr_ptr becomes 1.
- Reset mid-operation: assert rst in EXEC. On the next edge rsp_valid=0, busy=0, alu_a=alu_b=alu_op=0, rr_ptr=0, and no response appears. The first request after reset deasserts is served normally.
- Sweep: 3 rounds x 8 op codes with random a and b on rotating requesters. Every rsp_data matches the ALU model for the latched operands.
